// File: rtl/mips_data_pkg.sv
// Shared definitions for the byte-addressable MIPS data memory: access size codes,
// controller states, and lane-mask and alignment helpers.
package mips_data_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // Bit i enables bits [8i+7:8i]. Offset 0 is the most significant byte (big-endian).
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b1000 >> off;
         SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = |off;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mips_data_lane.sv
// Combinational big-endian lane extract with sign or zero extension.
// Used on the read path of mips_data_ram.
module mips_data_lane
   import mips_data_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[31:24];
      case (offset)
         2'd0:    byte_sel = word[31:24];
         2'd1:    byte_sel = word[23:16];
         2'd2:    byte_sel = word[15:8];
         default: byte_sel = word[7:0];
      endcase
      half_sel = offset[1] ? word[15:0] : word[31:16];

      case (size)
         SZ_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         SZ_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mips_data_ram.sv
// Byte-addressable data memory: byte, half and word access, registered reads, and a reset-time clear engine.
// Defining MIPS_DATA_BYPASS_EN forwards same-edge write data to the read; otherwise reads see the old word.
module mips_data_ram
   import mips_data_pkg::*;
#(
   parameter int DEPTH        = 256,
   parameter int ADDR_W       = 32,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] adr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              rvalid,
   output logic              busy,
   output logic              misalign
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic [31:0]       data_out_q, data_out_d;
   logic              rvalid_q, rvalid_d;
   logic              misalign_q, misalign_d;

   logic [IDX_W-1:0]  idx;
   logic [1:0]        off;
   logic              mis;
   logic [3:0]        mask;
   logic [31:0]       old_word;
   logic [31:0]       wr_lanes;
   logic [31:0]       merged;
   logic [31:0]       rd_word;
   logic [31:0]       rd_ext;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [31:0]       wr_data;
   logic              unused_adr_hi;

   // Address bits above the array wrap and carry no information.
   assign unused_adr_hi = ^adr[ADDR_W-1:IDX_W+2];

   assign idx      = adr[2 +: IDX_W];
   assign off      = adr[1:0];
   assign mis      = is_misaligned(size, off);
   assign mask     = lane_mask(size, off);
   assign old_word = mem_q[idx];

   always_comb begin
      case (size)
         SZ_BYTE: wr_lanes = {4{data_in[7:0]}};
         SZ_HALF: wr_lanes = {2{data_in[15:0]}};
         default: wr_lanes = data_in;
      endcase
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mask[i] ? wr_lanes[8*i +: 8] : old_word[8*i +: 8];
      end
   end

`ifdef MIPS_DATA_BYPASS_EN
   assign rd_word = mem_write ? merged : old_word;
`else
   assign rd_word = old_word;
`endif

   mips_data_lane u_lane (
      .word     (rd_word),
      .offset   (off),
      .size     (size),
      .sign_ext (sign_ext),
      .result   (rd_ext)
   );

   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      data_out_d = data_out_q;
      rvalid_d   = 1'b0;
      misalign_d = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = idx;
      wr_data    = merged;

      case (state_q)
         ST_CLEAR: begin
            wr_en     = 1'b1;
            wr_idx    = clr_ptr_q;
            wr_data   = 32'h0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            if (mem_read || mem_write) begin
               if (mis) begin
                  misalign_d = 1'b1;
               end else begin
                  wr_en = mem_write;
                  if (mem_read) begin
                     data_out_d = rd_ext;
                     rvalid_d   = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
         clr_ptr_q  <= '0;
         data_out_q <= 32'h0;
         rvalid_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         data_out_q <= data_out_d;
         rvalid_q   <= rvalid_d;
         misalign_q <= misalign_d;
      end
   end

   // Array has no reset; contents change only through the clear engine or serviced writes.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign data_out = data_out_q;
   assign rvalid   = rvalid_q;
   assign misalign = misalign_q;
   assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mips_data_ram.sv
// Scoreboard bench for mips_data_ram: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_mips_data_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] adr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        rvalid;
   logic        busy;
   logic        misalign;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        is_mis;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   mips_data_ram #(
      .DEPTH        (256),
      .ADDR_W       (32),
      .CLEAR_ON_RST (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .size      (size),
      .sign_ext  (sign_ext),
      .adr       (adr),
      .data_in   (data_in),
      .data_out  (data_out),
      .rvalid    (rvalid),
      .busy      (busy),
      .misalign  (misalign)
   );

   // Monitor
   always @(negedge clk) begin
      if (rvalid || misalign) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output rvalid=%0b misalign=%0b data_out=%h required=no_output",
                     rvalid, misalign, data_out);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.is_mis) begin
               if (!misalign || rvalid) begin
                  failures++;
                  $display("FAIL %s misalign=%0b rvalid=%0b required misalign=1 rvalid=0",
                           mon_e.name, misalign, rvalid);
               end
            end else if (!rvalid || misalign || data_out !== mon_e.data) begin
               failures++;
               $display("FAIL %s data_out=%h rvalid=%0b misalign=%0b required data_out=%h rvalid=1 misalign=0",
                        mon_e.name, data_out, rvalid, misalign, mon_e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // One request lasting one clock edge; expected response queued before the edge.
   task automatic issue(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_mis, input logic [31:0] exp_d);
      exp_t e;
      mem_read  = rd;
      mem_write = wr;
      size      = sz;
      sign_ext  = sx;
      adr       = a;
      data_in   = d;
      if (exp_mis) begin
         e.is_mis = 1'b1; e.data = 32'h0; e.name = name;
         sb_q.push_back(e);
      end else if (rd) begin
         e.is_mis = 1'b0; e.data = exp_d; e.name = name;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      @(negedge clk);
      while (busy && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   int          busy_cnt;
   logic [31:0] bypass_exp;

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = 2'b10;
      sign_ext = 1'b0; adr = 32'h0; data_in = 32'h0;
`ifdef MIPS_DATA_BYPASS_EN
      bypass_exp = 32'hDEADBEEF;
`else
      bypass_exp = 32'h0;
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'h0, busy}, 32'h1);
      check("reset_data_out", data_out, 32'h0);
      check("reset_rvalid", {31'h0, rvalid}, 32'h0);
      check("reset_misalign", {31'h0, misalign}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      count_busy(busy_cnt);
      check("clear_cycles", busy_cnt, 32'd256);

      issue("rd_word_3fc", 1, 0, 2'b10, 0, 32'h3FC, 0, 0, 32'h0);
      issue("wr_word_10",  0, 1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0);
      issue("lbu_13",      1, 0, 2'b00, 0, 32'h13, 0, 0, 32'h00000044);
      issue("lb_10",       1, 0, 2'b00, 1, 32'h10, 0, 0, 32'h00000011);
      issue("lhu_12",      1, 0, 2'b01, 0, 32'h12, 0, 0, 32'h00003344);
      issue("sb_21",       0, 1, 2'b00, 0, 32'h21, 32'h000000AB, 0, 0);
      issue("rd_word_20",  1, 0, 2'b10, 0, 32'h20, 0, 0, 32'h00AB0000);
      issue("lb_21",       1, 0, 2'b00, 1, 32'h21, 0, 0, 32'hFFFFFFAB);
      issue("lh_20",       1, 0, 2'b01, 1, 32'h20, 0, 0, 32'h000000AB);
      issue("sh_32",       0, 1, 2'b01, 0, 32'h32, 32'hFFFF8001, 0, 0);
      issue("lh_32",       1, 0, 2'b01, 1, 32'h32, 0, 0, 32'hFFFF8001);
      issue("lhu_32",      1, 0, 2'b01, 0, 32'h32, 0, 0, 32'h00008001);
      issue("rd_word_30",  1, 0, 2'b10, 0, 32'h30, 0, 0, 32'h00008001);
      issue("sw_mis_02",   0, 1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 1, 0);
      issue("rd_word_00",  1, 0, 2'b10, 0, 32'h00, 0, 0, 32'h0);
      issue("lh_mis_11",   1, 0, 2'b01, 1, 32'h11, 0, 1, 0);
      @(negedge clk);
      check("hold_after_mis", data_out, 32'h0);
      issue("rd_size11_10", 1, 0, 2'b11, 1, 32'h10, 0, 0, 32'h11223344);
      issue("rd_wrap_410",  1, 0, 2'b10, 0, 32'h410, 0, 0, 32'h11223344);
      issue("same_edge_40", 1, 1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 0, bypass_exp);
      issue("rd_word_40",   1, 0, 2'b10, 0, 32'h40, 0, 0, 32'hDEADBEEF);
      repeat (3) @(negedge clk);
      check("hold_idle", data_out, 32'hDEADBEEF);

      // Reset in the middle of a clear restarts the walk.
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (100) @(negedge clk);
      check("busy_mid_clear", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      count_busy(busy_cnt);
      check("clear_restart_cycles", busy_cnt, 32'd256);
      issue("rd_after_clear_10", 1, 0, 2'b10, 0, 32'h10, 0, 0, 32'h0);
      issue("rd_after_clear_40", 1, 0, 2'b10, 0, 32'h40, 0, 0, 32'h0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_data_ram.md
# mips_data_ram

Parametrised, byte-addressable data memory for the single-cycle MIPS datapath; the successor to the fixed 256-word word-only data memory. It supports byte, halfword and word accesses with big-endian lane selection and optional sign extension. Reads are registered on the rising edge with a valid strobe. A reset-time clear engine zeroes the array, and misaligned accesses are flagged. It sits between the ALU address output and the write-back mux.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, minimum 4.
- ADDR_W, 32, width of the byte address port.
- CLEAR_ON_RST, 1, when 1 reset runs the clear engine; when 0 array contents are untouched by reset.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- mem_read  in  1  read request, sampled at posedge.
- mem_write  in  1  write request, sampled at posedge.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- sign_ext  in  1  1 = sign-extend byte/half reads (lb/lh); 0 = zero-extend (lbu/lhu).
- adr  in  ADDR_W  byte address.
- data_in  in  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- data_out  out  32  registered read data, right-aligned and extended.
- rvalid  out  1  1-cycle pulse: data_out updated by a read.
- busy  out  1  clear engine active; requests ignored.
- misalign  out  1  1-cycle pulse: previous request was misaligned and suppressed.

## Operation
- Word index = adr[2 +: log2(DEPTH)]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Big-endian lanes: byte offset 0 -> bits [31:24], offset 3 -> [7:0]; half offset 0 -> [31:16], offset 2 -> [15:0].
- Alignment rule:
  - half requires adr[0]=0;
  - word requires adr[1:0]=00;
  - a violating request writes nothing, leaves data_out unchanged, keeps rvalid 0 and pulses misalign.
- Write: only the selected byte lanes are updated; the other lanes keep their value.
- Read: the selected lane is extracted, right-aligned and extended per sign_ext; word reads ignore sign_ext.
- Simultaneous mem_read and mem_write to the same word: the write commits. Read data follows Configuration.
- State machine (2 states):
  - CLEAR: clr_ptr walks 0..DEPTH-1, writing 32'h0 one word per cycle; busy=1; mem_read/mem_write ignored; rvalid=0, misalign=0. At clr_ptr=DEPTH-1, next state is RUN.
  - RUN: normal service; busy=0.
- rst (any state, including mid-clear):
  - with CLEAR_ON_RST=1: state becomes CLEAR and clr_ptr becomes 0;
  - with CLEAR_ON_RST=0: state becomes RUN.
- Reset values: data_out=0, rvalid=0, misalign=0, busy=CLEAR_ON_RST.

## Timing
- Read latency 1: request at edge N, data_out/rvalid valid after edge N, i.e. during cycle N+1.
- data_out holds its last value when no read completes.
- Write visible to a read issued at the next edge.
- Clear takes exactly DEPTH cycles after rst deasserts. The first serviced request is at edge DEPTH+1 after the last rst cycle.
- No input handshake beyond busy; the master must not issue requests while busy=1.

## Configuration
- MIPS_DATA_BYPASS_EN defined:
  - a same-edge read and write to the same word returns the merged new word (data_in lanes over old contents), then extracts.
- MIPS_DATA_BYPASS_EN undefined:
  - the read returns the old array contents (read-before-write).

## Structure
- Package mips_data_pkg:
  - size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state typedef (ST_CLEAR, ST_RUN);
  - a function for lane-enable mask from size and offset.
- Sub-module mips_data_lane: combinational lane extract plus sign/zero extension.
  - Inputs: word, offset, size, sign_ext.
  - Output: 32-bit result.
- The top level holds the array, FSM, clr_ptr and output registers.

## Test plan
- Reset with CLEAR_ON_RST=1, DEPTH=256: busy=1 for 256 cycles, then 0. A word read of adr 0x3FC returns 0, rvalid pulses once.
- Write word 0x11223344 @0x10, then read lb @0x13 -> 0x00000044. Then read lb @0x10 with sign_ext=1 -> 0x00000011. Then read lh @0x12 -> 0x00003344.
- Write sb 0xAB @0x21 over word 0; read word @0x20 -> 0x00AB0000. Read lb @0x21 sign_ext=1 -> 0xFFFFFFAB.
- Word write @0x02 -> misalign pulse, no write, rvalid=0. Read @0x00 -> unchanged contents.
- Assert rst at clear cycle 100 -> clr_ptr restarts. busy stays high 256 more cycles.
- Same-edge write 0xDEADBEEF and read @0x40 where the old contents are 0x0:
  - bypass defined: data_out=0xDEADBEEF;
  - bypass undefined: data_out=0x0.
